// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and word/index types for the multi-port register file.
package reg_file_pkg;
    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    typedef logic [XLEN_DEF-1:0] word_t;
    typedef logic [AW_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one combinational read port with write-first bypass and busy gating.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                            en,
    input  logic [AW-1:0]                   idx,
    input  logic [NREGS-1:0][XLEN-1:0]      regs,
    input  logic [NREGS-1:0]                pending,
    input  logic [NWR-1:0]                  wr_en,
    input  logic [NWR*AW-1:0]               wr_idx,
    input  logic [NWR*XLEN-1:0]             wr_data,
    output logic [XLEN-1:0]                 data,
    output logic                            busy
);
    logic hit;

    // Later write ports overwrite earlier matches, so the highest port wins.
    always_comb begin
        data = regs[idx];
        hit  = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_idx[w*AW +: AW] == idx) begin
                data = wr_data[w*XLEN +: XLEN];
                hit  = 1'b1;
            end
        end
        if (!en || idx == '0) data = '0;
        busy = en && idx != '0 && pending[idx] && !hit;
    end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with per-register pending scoreboard.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   rd_idx,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_idx,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_idx,
    output logic [AW:0]         busy_cnt
);
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           pending;
    logic [NREGS-1:0]           pending_nxt;

    // A reserve in the same cycle as a write names a new producer, so it wins.
    always_comb begin
        pending_nxt = pending;
        for (int w = 0; w < NWR; w++)
            if (wr_en[w]) pending_nxt[wr_idx[w*AW +: AW]] = 1'b0;
        if (rsv_en) pending_nxt[rsv_idx] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs     <= '0;
            pending  <= '0;
            busy_cnt <= '0;
        end else begin
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && wr_idx[w*AW +: AW] != '0)
                    regs[wr_idx[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
            pending  <= pending_nxt;
            busy_cnt <= (AW+1)'($countones(pending_nxt));
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        reg_file_rd_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .NWR   (NWR),
            .AW    (AW)
        ) u_rd (
            .en      (reset_n),
            .idx     (rd_idx[p*AW +: AW]),
            .regs    (regs),
            .pending (pending),
            .wr_en   (wr_en),
            .wr_idx  (wr_idx),
            .wr_data (wr_data),
            .data    (rd_data[p*XLEN +: XLEN]),
            .busy    (rd_busy[p])
        );
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: vector table plus reset corner sequences for reg_file_mp.
module tb_reg_file_mp;
    import reg_file_pkg::*;

    localparam int XLEN = 64, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NRD*AW-1:0]   rd_idx = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en = '0;
    logic [NWR*AW-1:0]   wr_idx = '0;
    logic [NWR*XLEN-1:0] wr_data = '0;
    logic                rsv_en = 1'b0;
    logic [AW-1:0]       rsv_idx = '0;
    logic [AW:0]         busy_cnt;

    int checks = 0;
    int errors = 0;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_idx  (rsv_idx),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] we;
        reg_idx_t   wi0;
        word_t      wd0;
        reg_idx_t   wi1;
        word_t      wd1;
        logic       rsv;
        reg_idx_t   ri;
        reg_idx_t   r0;
        reg_idx_t   r1;
        word_t      e0;
        word_t      e1;
        logic       eb0;
        logic       eb1;
        logic [5:0] ecnt;
    } vec_t;

    typedef struct {
        word_t      d0;
        word_t      d1;
        logic       b0;
        logic       b1;
        logic [5:0] cnt;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];

    function automatic vec_t mk(logic [1:0] we, reg_idx_t wi0, word_t wd0, reg_idx_t wi1, word_t wd1,
                                logic rsv, reg_idx_t ri, reg_idx_t r0, reg_idx_t r1,
                                word_t e0, word_t e1, logic eb0, logic eb1, logic [5:0] ecnt);
        vec_t v;
        v.we = we; v.wi0 = wi0; v.wd0 = wd0; v.wi1 = wi1; v.wd1 = wd1;
        v.rsv = rsv; v.ri = ri; v.r0 = r0; v.r1 = r1;
        v.e0 = e0; v.e1 = e1; v.eb0 = eb0; v.eb1 = eb1; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic [1:0] we, reg_idx_t wi0, word_t wd0, reg_idx_t wi1, word_t wd1,
                         logic rsv, reg_idx_t ri, reg_idx_t r0, reg_idx_t r1);
        wr_en   = we;
        wr_idx  = {wi1, wi0};
        wr_data = {wd1, wd0};
        rsv_en  = rsv;
        rsv_idx = ri;
        rd_idx  = {r1, r0};
    endtask

    initial begin
        exp_t e;
        vecs[0]  = mk(2'b01, 5, 64'hDEAD_BEEF, 0, 0,     0, 0, 5, 5,  64'hDEAD_BEEF, 64'hDEAD_BEEF, 0, 0, 0);
        vecs[1]  = mk(2'b00, 0, 0, 0, 0,                 0, 0, 5, 0,  64'hDEAD_BEEF, 0, 0, 0, 0);
        vecs[2]  = mk(2'b11, 7, 64'h11, 7, 64'h22,       0, 0, 7, 7,  64'h22, 64'h22, 0, 0, 0);
        vecs[3]  = mk(2'b00, 0, 0, 0, 0,                 0, 0, 7, 5,  64'h22, 64'hDEAD_BEEF, 0, 0, 0);
        vecs[4]  = mk(2'b01, 0, 64'hFFFF, 0, 0,          1, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[5]  = mk(2'b00, 0, 0, 0, 0,                 0, 0, 0, 7,  0, 64'h22, 0, 0, 0);
        vecs[6]  = mk(2'b00, 0, 0, 0, 0,                 1, 3, 3, 3,  0, 0, 0, 0, 1);
        vecs[7]  = mk(2'b00, 0, 0, 0, 0,                 0, 0, 3, 5,  0, 64'hDEAD_BEEF, 1, 0, 1);
        vecs[8]  = mk(2'b10, 0, 0, 3, 64'h33,            0, 0, 3, 3,  64'h33, 64'h33, 0, 0, 0);
        vecs[9]  = mk(2'b00, 0, 0, 0, 0,                 0, 0, 3, 3,  64'h33, 64'h33, 0, 0, 0);
        vecs[10] = mk(2'b01, 3, 64'h44, 0, 0,            1, 3, 3, 0,  64'h44, 0, 0, 0, 1);
        vecs[11] = mk(2'b00, 0, 0, 0, 0,                 0, 0, 3, 3,  64'h44, 64'h44, 1, 1, 1);
        vecs[12] = mk(2'b00, 0, 0, 0, 0,                 1, 3, 3, 3,  64'h44, 64'h44, 1, 1, 1);
        vecs[13] = mk(2'b01, 12, 64'hC, 0, 0,            1, 8, 8, 12, 0, 64'hC, 0, 0, 2);
        vecs[14] = mk(2'b11, 3, 64'h55, 8, 64'h88,       0, 0, 8, 3,  64'h88, 64'h55, 0, 0, 0);
        vecs[15] = mk(2'b11, 9, 64'h1, 10, 64'h2,        0, 0, 10, 9, 64'h2, 64'h1, 0, 0, 0);

        // Reset held: outputs must be quiet even with a write and reserve requested.
        drive(2'b01, 6, 64'hABCD, 0, 0, 1, 6, 6, 6);
        repeat (2) @(negedge clk);
        chk("rst_hold_d0", rd_data[63:0], 0);
        chk("rst_hold_b", {62'd0, rd_busy}, 0);
        chk("rst_hold_cnt", {58'd0, busy_cnt}, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        for (int i = 0; i < NREGS; i++) begin
            @(negedge clk);
            rd_idx = {5'(NREGS-1-i), 5'(i)};
            #1;
            chk("rst_rd0", rd_data[63:0], 0);
            chk("rst_rd1", rd_data[127:64], 0);
            chk("rst_busy", {62'd0, rd_busy}, 0);
        end
        chk("rst_cnt", {58'd0, busy_cnt}, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].wi0, vecs[i].wd0, vecs[i].wi1, vecs[i].wd1,
                  vecs[i].rsv, vecs[i].ri, vecs[i].r0, vecs[i].r1);
            sb.push_back('{vecs[i].e0, vecs[i].e1, vecs[i].eb0, vecs[i].eb1, vecs[i].ecnt});
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_d0", i), rd_data[63:0], e.d0);
            chk($sformatf("v%0d_d1", i), rd_data[127:64], e.d1);
            chk($sformatf("v%0d_b0", i), {63'd0, rd_busy[0]}, {63'd0, e.b0});
            chk($sformatf("v%0d_b1", i), {63'd0, rd_busy[1]}, {63'd0, e.b1});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cnt", i), {58'd0, busy_cnt}, {58'd0, e.cnt});
        end

        // Reserve 4, then reset mid-cycle while a write and reserve are in flight.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 4, 4, 4);
        @(posedge clk);
        #1;
        chk("r4_cnt", {58'd0, busy_cnt}, 1);
        @(negedge clk);
        drive(2'b01, 9, 64'h5A, 0, 0, 1, 4, 9, 4);
        #1;
        chk("pre_rst_d0", rd_data[63:0], 64'h5A);
        chk("pre_rst_b1", {63'd0, rd_busy[1]}, 1);
        reset_n = 1'b0;
        #1;
        chk("async_d0", rd_data[63:0], 0);
        chk("async_b", {62'd0, rd_busy}, 0);
        chk("async_cnt", {58'd0, busy_cnt}, 0);
        rd_idx[9:5] = 5'd5;
        #1;
        chk("async_reg5", rd_data[127:64], 0);
        @(posedge clk);
        #1;
        chk("held_d0", rd_data[63:0], 0);
        chk("held_cnt", {58'd0, busy_cnt}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(2'b01, 9, 64'h77, 0, 0, 1, 4, 9, 4);
        #1;
        chk("rel_bypass", rd_data[63:0], 64'h77);
        chk("rel_b1", {63'd0, rd_busy[1]}, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 9, 4);
        #1;
        chk("rel_d0", rd_data[63:0], 64'h77);
        chk("rel_b1_after", {63'd0, rd_busy[1]}, 1);
        chk("rel_cnt", {58'd0, busy_cnt}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
